// File: rtl/jtag_pkg.sv
// Shared JTAG TAP types, IR opcodes and the seven-segment digit encoder
// for the board debug top.
package jtag_pkg;

  localparam int IR_W = 5;

  localparam logic [IR_W-1:0] IR_IDCODE = 5'h01;
  localparam logic [IR_W-1:0] IR_USER   = 5'h0A;
  localparam logic [IR_W-1:0] IR_STATUS = 5'h10;
  localparam logic [IR_W-1:0] IR_BYPASS = 5'h1F;

  typedef enum logic [3:0] {
    TAP_RESET, TAP_IDLE,
    TAP_SEL_DR, TAP_CAP_DR, TAP_SH_DR, TAP_EX1_DR, TAP_PAU_DR, TAP_EX2_DR, TAP_UPD_DR,
    TAP_SEL_IR, TAP_CAP_IR, TAP_SH_IR, TAP_EX1_IR, TAP_PAU_IR, TAP_EX2_IR, TAP_UPD_IR
  } tap_state_t;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    case (s)
      TAP_RESET:  return tms ? TAP_RESET  : TAP_IDLE;
      TAP_IDLE:   return tms ? TAP_SEL_DR : TAP_IDLE;
      TAP_SEL_DR: return tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: return tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  return tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: return tms ? TAP_UPD_DR : TAP_PAU_DR;
      TAP_PAU_DR: return tms ? TAP_EX2_DR : TAP_PAU_DR;
      TAP_EX2_DR: return tms ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: return tms ? TAP_SEL_DR : TAP_IDLE;
      TAP_SEL_IR: return tms ? TAP_RESET  : TAP_CAP_IR;
      TAP_CAP_IR: return tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  return tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: return tms ? TAP_UPD_IR : TAP_PAU_IR;
      TAP_PAU_IR: return tms ? TAP_EX2_IR : TAP_PAU_IR;
      TAP_EX2_IR: return tms ? TAP_UPD_IR : TAP_SH_IR;
      default:    return tms ? TAP_SEL_DR : TAP_IDLE;
    endcase
  endfunction

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7seg(input logic [3:0] d);
    case (d)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tap.sv
// IEEE 1149.1 TAP oversampled in the clock_50 domain: input synchronizers,
// 16-state FSM, 5-bit IR, shared 32-bit DR shifter and registered tdo.
//
// state        | meaning
// TAP_RESET    | test-logic-reset, IR forced to IDCODE
// TAP_IDLE     | run-test/idle
// *_SEL_*      | select DR / IR scan column
// *_CAP_*      | capture parallel value into shifter
// *_SH_*       | shift one bit per tck rise, LSB out first
// *_EX*/PAU_*  | exit1 / pause / exit2 holding states
// *_UPD_*      | update: load IR, or strobe USER write
module jtag_tap
  import jtag_pkg::*;
#(
  parameter logic [31:0] IDCODE = 32'h1000_0001
) (
  input  logic            clock_50,
  input  logic            rst,
  input  logic            tck,
  input  logic            tms,
  input  logic            tdi,
  input  logic            n_trst,
  input  logic            n_rst,
  input  logic [31:0]     user_val,
  input  logic [31:0]     status_val,
  output logic            tdo,
  output logic            user_we,
  output logic [31:0]     user_wdata,
  output logic [IR_W-1:0] ir,
  output logic            n_rst_sync
);

  logic [2:0]      tck_q, tck_d;
  logic [1:0]      tms_q, tms_d, tdi_q, tdi_d, ntrst_q, ntrst_d, nrst_q, nrst_d;
  tap_state_t      state_q, state_d;
  logic [IR_W-1:0] ir_q, ir_d, ir_sh_q, ir_sh_d;
  logic [31:0]     dr_sh_q, dr_sh_d;
  logic            tdo_q, tdo_d, user_we_q, user_we_d;
  logic            rise, fall, tms_s, tdi_s, bypass;

  assign rise   = tck_q[1] & ~tck_q[2];
  assign fall   = ~tck_q[1] & tck_q[2];
  assign tms_s  = tms_q[1];
  assign tdi_s  = tdi_q[1];
  assign bypass = !(ir_q inside {IR_IDCODE, IR_USER, IR_STATUS});

  always_comb begin
    tck_d     = {tck_q[1:0], tck};
    tms_d     = {tms_q[0], tms};
    tdi_d     = {tdi_q[0], tdi};
    ntrst_d   = {ntrst_q[0], n_trst};
    nrst_d    = {nrst_q[0], n_rst};
    state_d   = state_q;
    ir_d      = ir_q;
    ir_sh_d   = ir_sh_q;
    dr_sh_d   = dr_sh_q;
    tdo_d     = tdo_q;
    user_we_d = 1'b0;

    if (state_q == TAP_RESET) ir_d = IR_IDCODE;

    if (rise) begin
      state_d = tap_next(state_q, tms_s);
      case (state_q)
        TAP_CAP_IR: ir_sh_d = 5'b00001;
        TAP_SH_IR:  ir_sh_d = {tdi_s, ir_sh_q[IR_W-1:1]};
        TAP_CAP_DR: begin
          case (ir_q)
            IR_IDCODE: dr_sh_d = IDCODE;
            IR_USER:   dr_sh_d = user_val;
            IR_STATUS: dr_sh_d = status_val;
            default:   dr_sh_d = '0;
          endcase
        end
        TAP_SH_DR: begin
          if (bypass) dr_sh_d[0] = tdi_s;
          else        dr_sh_d    = {tdi_s, dr_sh_q[31:1]};
        end
        default: ;
      endcase
      if (state_d == TAP_UPD_IR) ir_d = ir_sh_q;
      if (state_d == TAP_UPD_DR && ir_q == IR_USER) user_we_d = 1'b1;
    end

    if (fall) begin
      if (state_q == TAP_SH_IR)      tdo_d = ir_sh_q[0];
      else if (state_q == TAP_SH_DR) tdo_d = dr_sh_q[0];
      else                           tdo_d = 1'b0;
    end

    if (!ntrst_q[1]) begin
      state_d   = TAP_RESET;
      user_we_d = 1'b0;
    end
  end

  always_ff @(posedge clock_50 or posedge rst) begin
    if (rst) begin
      tck_q     <= '0;
      tms_q     <= '0;
      tdi_q     <= '0;
      ntrst_q   <= '1;
      nrst_q    <= '1;
      state_q   <= TAP_RESET;
      ir_q      <= IR_IDCODE;
      ir_sh_q   <= '0;
      dr_sh_q   <= '0;
      tdo_q     <= 1'b0;
      user_we_q <= 1'b0;
    end else begin
      tck_q     <= tck_d;
      tms_q     <= tms_d;
      tdi_q     <= tdi_d;
      ntrst_q   <= ntrst_d;
      nrst_q    <= nrst_d;
      state_q   <= state_d;
      ir_q      <= ir_d;
      ir_sh_q   <= ir_sh_d;
      dr_sh_q   <= dr_sh_d;
      tdo_q     <= tdo_d;
      user_we_q <= user_we_d;
    end
  end

  assign tdo        = tdo_q;
  assign user_we    = user_we_q;
  assign user_wdata = dr_sh_q;
  assign ir         = ir_q;
  assign n_rst_sync = nrst_q[1];

endmodule

// File: rtl/sys_pll.sv
// Behavioural stand-in for the vendor PLL wrapper (50 MHz in, 50 MHz out);
// the board build replaces this file with the generated vendor IP.
module sys_pll (
  input  logic clk_in,
  output logic clk_out
);
  assign clk_out = clk_in;
endmodule

// File: rtl/board_debug_top.sv
// Board top: JTAG TAP, JTAG-writable USER register on LEDs and hex displays.
// Define BOARD_HEX_DISPLAY_EN to drive the hex digits; otherwise they stay blank.
module board_debug_top
  import jtag_pkg::*;
#(
  parameter int          PLL    = 1,
  parameter logic [31:0] IDCODE = 32'h1000_0001
) (
  input  logic       clock_50,
  input  logic       rst,
  input  logic [3:0] key,
  input  logic [9:0] sw,
  output logic [9:0] led,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  input  logic       tck,
  input  logic       tms,
  input  logic       tdi,
  output logic       tdo,
  input  logic       n_trst,
  input  logic       n_rst,
  output logic       vt_ref
);

  logic            clk_sys;
  logic [31:0]     user_q, user_d;
  logic            user_we, n_rst_s;
  logic [31:0]     user_wdata;
  logic [IR_W-1:0] ir_unused;
  logic            unused_key0;

  if (PLL != 0) begin : g_pll
    sys_pll u_sys_pll (.clk_in(clock_50), .clk_out(clk_sys));
  end else begin : g_no_pll
    assign clk_sys = clock_50;
  end

  // key[0] is consumed by the board wrapper as the reset source.
  assign unused_key0 = key[0];

  jtag_tap #(.IDCODE(IDCODE)) u_tap (
    .clock_50   (clk_sys),
    .rst        (rst),
    .tck        (tck),
    .tms        (tms),
    .tdi        (tdi),
    .n_trst     (n_trst),
    .n_rst      (n_rst),
    .user_val   (user_q),
    .status_val ({16'h0, 3'b0, ~key[3:1], sw}),
    .tdo        (tdo),
    .user_we    (user_we),
    .user_wdata (user_wdata),
    .ir         (ir_unused),
    .n_rst_sync (n_rst_s)
  );

  always_comb begin
    user_d = user_q;
    if (!n_rst_s)     user_d = '0;
    else if (user_we) user_d = user_wdata;
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) user_q <= '0;
    else     user_q <= user_d;
  end

  assign led    = user_q[9:0];
  assign vt_ref = 1'b1;

`ifdef BOARD_HEX_DISPLAY_EN
  assign hex0 = hex7seg(user_q[3:0]);
  assign hex1 = hex7seg(user_q[7:4]);
  assign hex2 = hex7seg(user_q[11:8]);
  assign hex3 = hex7seg(user_q[15:12]);
  assign hex4 = hex7seg(user_q[19:16]);
  assign hex5 = hex7seg(user_q[23:20]);
`else
  assign hex0 = 7'h7F;
  assign hex1 = 7'h7F;
  assign hex2 = 7'h7F;
  assign hex3 = 7'h7F;
  assign hex4 = 7'h7F;
  assign hex5 = 7'h7F;
`endif

endmodule

// File: tb/tb_board_debug_top.sv
// Directed bench for board_debug_top: drives JTAG scans with a slow tck and
// checks tdo streams, USER visibility on LEDs/hex and the reset sources.
module tb_board_debug_top;

  logic       clock_50 = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key = 4'hF;
  logic [9:0] sw = '0;
  logic [9:0] led;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic       tck = 1'b0, tms = 1'b0, tdi = 1'b0;
  logic       n_trst = 1'b1, n_rst = 1'b1;
  logic       tdo, vt_ref;
  logic [41:0] hex_all;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] EXP_ID = 32'h1000_0001;

  always #10 clock_50 = ~clock_50;

  assign hex_all = {hex5, hex4, hex3, hex2, hex1, hex0};

  board_debug_top #(.PLL(0)) dut (
    .clock_50(clock_50), .rst(rst), .key(key), .sw(sw), .led(led),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo),
    .n_trst(n_trst), .n_rst(n_rst), .vt_ref(vt_ref)
  );

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] r;
    case (n)
      4'h0: r = 7'h40;  4'h1: r = 7'h79;  4'h2: r = 7'h24;  4'h3: r = 7'h30;
      4'h4: r = 7'h19;  4'h5: r = 7'h12;  4'h6: r = 7'h02;  4'h7: r = 7'h78;
      4'h8: r = 7'h00;  4'h9: r = 7'h10;  4'hA: r = 7'h08;  4'hB: r = 7'h03;
      4'hC: r = 7'h46;  4'hD: r = 7'h21;  4'hE: r = 7'h06;  default: r = 7'h0E;
    endcase
`ifndef BOARD_HEX_DISPLAY_EN
    r = 7'h7F;
`endif
    return r;
  endfunction

  function automatic logic [41:0] exp_hex(input logic [31:0] u);
    logic [41:0] r;
    for (int i = 0; i < 6; i++) r[7*i +: 7] = seg(u[4*i +: 4]);
    return r;
  endfunction

  // One full tck period (5 clocks high, 5 low); tdo sampled late in the low phase.
  task automatic tck_pulse(input logic tms_v, input logic tdi_v, output logic tdo_v);
    @(negedge clock_50);
    tms = tms_v;
    tdi = tdi_v;
    tck = 1'b1;
    repeat (5) @(negedge clock_50);
    tck = 1'b0;
    repeat (5) @(negedge clock_50);
    tdo_v = tdo;
  endtask

  task automatic go_idle();
    logic t;
    for (int i = 0; i < 5; i++) tck_pulse(1'b1, 1'b0, t);
    tck_pulse(1'b0, 1'b0, t);
  endtask

  // From Run-Test-Idle to Exit1-DR, shifting din in and collecting dout.
  task automatic dr_scan(input logic [31:0] din, output logic [31:0] dout);
    logic t;
    tck_pulse(1'b1, 1'b0, t);
    tck_pulse(1'b0, 1'b0, t);
    tck_pulse(1'b0, 1'b0, t);
    dout[0] = t;
    for (int i = 0; i < 32; i++) begin
      tck_pulse(i == 31, din[i], t);
      if (i < 31) dout[i+1] = t;
    end
  endtask

  task automatic finish_update();
    logic t;
    tck_pulse(1'b1, 1'b0, t);
    tck_pulse(1'b0, 1'b0, t);
  endtask

  task automatic shift_dr(input logic [31:0] din, output logic [31:0] dout);
    dr_scan(din, dout);
    finish_update();
  endtask

  task automatic shift_ir(input logic [4:0] din, output logic [4:0] dout);
    logic t;
    tck_pulse(1'b1, 1'b0, t);
    tck_pulse(1'b1, 1'b0, t);
    tck_pulse(1'b0, 1'b0, t);
    tck_pulse(1'b0, 1'b0, t);
    dout[0] = t;
    for (int i = 0; i < 5; i++) begin
      tck_pulse(i == 4, din[i], t);
      if (i < 4) dout[i+1] = t;
    end
    finish_update();
  endtask

  task automatic test_reset();
    @(negedge clock_50);
    rst = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock_50);
      n_checks++;
      if (led !== 10'h0 || hex_all !== exp_hex(32'h0) || tdo !== 1'b0 || vt_ref !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_state cycle %0d: led=%h hex=%h tdo=%b vt_ref=%b, required led=000 hex=%h tdo=0 vt_ref=1",
                 i, led, hex_all, tdo, vt_ref, exp_hex(32'h0));
        break;
      end
    end
  endtask

  task automatic test_idcode();
    logic [31:0] d;
    go_idle();
    shift_dr(32'h0, d);
    n_checks++;
    if (d !== EXP_ID) begin
      n_fail++; $display("FAIL idcode_read: got %h, required %h", d, EXP_ID);
    end
    n_checks++;
    if (tdo !== 1'b0) begin
      n_fail++; $display("FAIL tdo_idle: got %b, required 0", tdo);
    end
  endtask

  task automatic test_user_write();
    logic [4:0]  irc;
    logic [31:0] d;
    shift_ir(5'h0A, irc);
    n_checks++;
    if (irc !== 5'b00001) begin
      n_fail++; $display("FAIL ir_capture: got %b, required 00001", irc);
    end
    dr_scan(32'h00AB_CDEF, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL user_capture_reset: got %h, required 00000000", d);
    end
    @(negedge clock_50);
    tms = 1'b1;
    tdi = 1'b0;
    tck = 1'b1;
    repeat (3) @(negedge clock_50);
    n_checks++;
    if (led !== 10'h0) begin
      n_fail++; $display("FAIL update_too_early: led=%h, required 000", led);
    end
    @(negedge clock_50);
    n_checks++;
    if (led !== 10'h1EF) begin
      n_fail++; $display("FAIL update_latency: led=%h, required 1ef", led);
    end
    n_checks++;
    if (hex_all !== exp_hex(32'h00AB_CDEF)) begin
      n_fail++; $display("FAIL hex_abcdef: got %h, required %h", hex_all, exp_hex(32'h00AB_CDEF));
    end
    @(negedge clock_50);
    tck = 1'b0;
    repeat (5) @(negedge clock_50);
    begin
      logic t;
      tck_pulse(1'b0, 1'b0, t);
    end
    shift_dr(32'h1234_5678, d);
    n_checks++;
    if (d !== 32'h00AB_CDEF) begin
      n_fail++; $display("FAIL user_readback: got %h, required 00abcdef", d);
    end
    n_checks++;
    if (led !== 10'h278 || hex_all !== exp_hex(32'h1234_5678)) begin
      n_fail++; $display("FAIL user_12345678: led=%h hex=%h, required led=278 hex=%h",
                         led, hex_all, exp_hex(32'h1234_5678));
    end
    shift_dr(32'h00AB_CDEF, d);
    n_checks++;
    if (d !== 32'h1234_5678) begin
      n_fail++; $display("FAIL user_readback2: got %h, required 12345678", d);
    end
  endtask

  task automatic test_bypass();
    logic [4:0]  irc;
    logic [31:0] d;
    logic [3:0]  obs;
    logic        t;
    shift_ir(5'h1F, irc);
    tck_pulse(1'b1, 1'b0, t);
    tck_pulse(1'b0, 1'b0, t);
    tck_pulse(1'b0, 1'b0, t);
    obs[3] = t;
    tck_pulse(1'b0, 1'b1, t);  obs[2] = t;
    tck_pulse(1'b0, 1'b0, t);  obs[1] = t;
    tck_pulse(1'b0, 1'b1, t);  obs[0] = t;
    tck_pulse(1'b1, 1'b1, t);
    finish_update();
    n_checks++;
    if (obs !== 4'b0101) begin
      n_fail++; $display("FAIL bypass_1f: tdo seq %b, required 0101", obs);
    end
    shift_ir(5'h03, irc);
    shift_dr(32'hA5A5_0F0F, d);
    n_checks++;
    if (d !== 32'h4B4A_1E1E) begin
      n_fail++; $display("FAIL bypass_other: got %h, required 4b4a1e1e", d);
    end
    n_checks++;
    if (led !== 10'h1EF) begin
      n_fail++; $display("FAIL bypass_no_write: led=%h, required 1ef", led);
    end
  endtask

  task automatic test_status();
    logic [4:0]  irc;
    logic [31:0] d;
    sw  = 10'h2A5;
    key = 4'b1011;
    shift_ir(5'h10, irc);
    shift_dr(32'hFFFF_FFFF, d);
    n_checks++;
    if (d !== 32'h0000_0AA5) begin
      n_fail++; $display("FAIL status_key1011: got %h, required 00000aa5", d);
    end
    key = 4'b0111;
    shift_dr(32'hFFFF_FFFF, d);
    n_checks++;
    if (d !== 32'h0000_12A5) begin
      n_fail++; $display("FAIL status_key0111: got %h, required 000012a5", d);
    end
    n_checks++;
    if (led !== 10'h1EF) begin
      n_fail++; $display("FAIL status_read_only: led=%h, required 1ef", led);
    end
    sw  = '0;
    key = 4'hF;
  endtask

  task automatic test_tms_reset();
    logic [31:0] d;
    logic        t;
    tck_pulse(1'b1, 1'b0, t);
    tck_pulse(1'b1, 1'b0, t);
    tck_pulse(1'b0, 1'b0, t);
    tck_pulse(1'b0, 1'b0, t);
    for (int i = 0; i < 5; i++) tck_pulse(1'b1, 1'b0, t);
    tck_pulse(1'b0, 1'b0, t);
    shift_dr(32'h0, d);
    n_checks++;
    if (d !== EXP_ID) begin
      n_fail++; $display("FAIL tms5_reset: got %h, required %h", d, EXP_ID);
    end
  endtask

  task automatic test_n_trst();
    logic [4:0]  irc;
    logic [31:0] d;
    logic        t;
    shift_ir(5'h0A, irc);
    @(negedge clock_50);
    n_trst = 1'b0;
    repeat (4) @(negedge clock_50);
    n_trst = 1'b1;
    repeat (4) @(negedge clock_50);
    tck_pulse(1'b0, 1'b0, t);
    shift_dr(32'h0, d);
    n_checks++;
    if (d !== EXP_ID) begin
      n_fail++; $display("FAIL n_trst_ir: got %h, required %h", d, EXP_ID);
    end
    n_checks++;
    if (led !== 10'h1EF) begin
      n_fail++; $display("FAIL n_trst_keeps_user: led=%h, required 1ef", led);
    end
  endtask

  task automatic test_n_rst();
    logic [4:0]  irc;
    logic [31:0] d;
    shift_ir(5'h0A, irc);
    @(negedge clock_50);
    n_rst = 1'b0;
    repeat (4) @(negedge clock_50);
    n_rst = 1'b1;
    repeat (4) @(negedge clock_50);
    n_checks++;
    if (led !== 10'h0 || hex_all !== exp_hex(32'h0)) begin
      n_fail++; $display("FAIL n_rst_clear: led=%h hex=%h, required led=000 hex=%h",
                         led, hex_all, exp_hex(32'h0));
    end
    shift_dr(32'h0000_0155, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL n_rst_keeps_tap: got %h, required 00000000", d);
    end
    n_checks++;
    if (led !== 10'h155) begin
      n_fail++; $display("FAIL write_after_n_rst: led=%h, required 155", led);
    end
  endtask

  task automatic test_nrst_vs_update();
    logic [31:0] d;
    @(negedge clock_50);
    n_rst = 1'b0;
    shift_dr(32'h0000_03C3, d);
    n_checks++;
    if (led !== 10'h0) begin
      n_fail++; $display("FAIL n_rst_beats_update: led=%h, required 000", led);
    end
    n_rst = 1'b1;
    repeat (4) @(negedge clock_50);
    shift_dr(32'h0, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL n_rst_update_user: got %h, required 00000000", d);
    end
  endtask

  task automatic test_rst_midshift();
    logic [4:0]  irc;
    logic [31:0] d;
    logic        t;
    shift_dr(32'h0000_02AA, d);
    tck_pulse(1'b1, 1'b0, t);
    tck_pulse(1'b0, 1'b0, t);
    tck_pulse(1'b0, 1'b0, t);
    for (int i = 0; i < 8; i++) tck_pulse(1'b0, 1'b1, t);
    @(negedge clock_50);
    rst = 1'b1;
    @(negedge clock_50);
    rst = 1'b0;
    n_checks++;
    if (led !== 10'h0 || tdo !== 1'b0) begin
      n_fail++; $display("FAIL rst_midshift: led=%h tdo=%b, required led=000 tdo=0", led, tdo);
    end
    tck_pulse(1'b1, 1'b1, t);
    tck_pulse(1'b1, 1'b1, t);
    tck_pulse(1'b0, 1'b0, t);
    shift_dr(32'h0, d);
    n_checks++;
    if (d !== EXP_ID || led !== 10'h0) begin
      n_fail++; $display("FAIL rst_tap_reset: dr=%h led=%h, required dr=%h led=000", d, led, EXP_ID);
    end
    shift_ir(5'h0A, irc);
    shift_dr(32'h0, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL rst_partial_discarded: got %h, required 00000000", d);
    end
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_user_write();
    test_bypass();
    test_status();
    test_tms_reset();
    test_n_trst();
    test_n_rst();
    test_nrst_vs_update();
    test_rst_midshift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
